// File: rtl/dmem_dump_arbiter_pkg.sv
// Shared types for the data-memory dump arbiter: FSM state encoding and port-ownership helper.
package dmem_dump_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        WAIT_HALT = 3'd1,
        READ      = 3'd2,
        WAIT_DATA = 3'd3,
        SEND      = 3'd4,
        CKSUM     = 3'd5,
        DONE      = 3'd6
    } state_t;

    // Once the pipeline has halted the dumper drives the RAM port until the dump ends.
    function automatic logic dumper_owns(state_t s);
        return (s == READ) || (s == WAIT_DATA) || (s == SEND) || (s == CKSUM) || (s == DONE);
    endfunction

endpackage

// File: rtl/dmem_dump_arbiter_if.sv
// Valid/ready stream carrying dumped words to the debug unit.
interface dmem_dump_arbiter_if #(
    parameter int NB_DATA = 32
) ();
    logic [NB_DATA-1:0] data;
    logic               valid;
    logic               ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/dmem_dump_arbiter_port_mux.sv
// RAM-port ownership mux: MEM stage passes straight through unless the dumper owns the port.
module dmem_port_mux #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               dumper_own,
    input  logic               mem_we,
    input  logic [NB_ADDR-1:0] mem_addr,
    input  logic [NB_DATA-1:0] mem_wdata,
    input  logic [NB_ADDR-1:0] dump_addr,
    output logic               ram_we,
    output logic [NB_ADDR-1:0] ram_addr,
    output logic [NB_DATA-1:0] ram_wdata
);
    // Stores issued while the dumper owns the port are dropped, never deferred.
    assign ram_we    = dumper_own ? 1'b0 : mem_we;
    assign ram_addr  = dumper_own ? dump_addr : mem_addr;
    assign ram_wdata = dumper_own ? '0 : mem_wdata;
endmodule

// File: rtl/dmem_dump_arbiter.sv
// Shares the data-memory RAM port between the MEM stage and a debug memory dumper.
// Optional DMEM_DUMP_CHECKSUM_EN appends a running-XOR beat after the last word.
module dmem_dump_arbiter
    import dmem_dump_pkg::*;
#(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDR    = 8,
    parameter int DUMP_FIRST = 0,
    parameter int DUMP_LAST  = 255
) (
    input  logic                clk,
    input  logic                i_reset,
    input  logic                i_mem_we,
    input  logic [NB_ADDR-1:0]  i_mem_addr,
    input  logic [NB_DATA-1:0]  i_mem_wdata,
    output logic [NB_DATA-1:0]  o_mem_rdata,
    input  logic                i_pipe_halted,
    output logic                o_stall,
    input  logic                i_dump_req,
    output logic                o_dump_busy,
    dmem_dump_arbiter_if.master dump,
    output logic                o_dump_done,
    output logic                o_ram_we,
    output logic [NB_ADDR-1:0]  o_ram_addr,
    output logic [NB_DATA-1:0]  o_ram_wdata,
    input  logic [NB_DATA-1:0]  i_ram_rdata
);
    localparam logic [NB_ADDR-1:0] FIRST_A = NB_ADDR'(DUMP_FIRST);
    localparam logic [NB_ADDR-1:0] LAST_A  = NB_ADDR'(DUMP_LAST);

    state_t               state;
    logic [NB_ADDR-1:0]   cnt;
    logic [NB_DATA-1:0]   dump_data;
    logic                 stall, busy, valid, done;
`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [NB_DATA-1:0]   cksum;
`endif

    wire hs = valid & dump.ready;
    // Reset hands the port back to MEM in the very cycle it is sampled.
    wire dumper_own = dumper_owns(state) & ~i_reset;

    assign o_mem_rdata = i_ram_rdata;
    assign o_stall     = stall;
    assign o_dump_busy = busy;
    assign o_dump_done = done;
    assign dump.data   = dump_data;
    assign dump.valid  = valid;

    dmem_port_mux #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) u_mux (
        .dumper_own (dumper_own),
        .mem_we     (i_mem_we),
        .mem_addr   (i_mem_addr),
        .mem_wdata  (i_mem_wdata),
        .dump_addr  (cnt),
        .ram_we     (o_ram_we),
        .ram_addr   (o_ram_addr),
        .ram_wdata  (o_ram_wdata)
    );

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state     <= IDLE;
            cnt       <= FIRST_A;
            dump_data <= '0;
            stall     <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            done      <= 1'b0;
`ifdef DMEM_DUMP_CHECKSUM_EN
            cksum     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (i_dump_req) begin
                    state <= WAIT_HALT;
                    stall <= 1'b1;
                    busy  <= 1'b1;
`ifdef DMEM_DUMP_CHECKSUM_EN
                    cksum <= '0;
`endif
                end
                WAIT_HALT: if (i_pipe_halted) state <= READ;
                READ:      state <= WAIT_DATA;
                WAIT_DATA: begin
                    dump_data <= i_ram_rdata;
                    valid     <= 1'b1;
                    state     <= SEND;
                end
                SEND: if (hs) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                    cksum <= cksum ^ dump_data;
`endif
                    if (cnt == LAST_A) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                        // valid stays high: the checksum beat follows back-to-back.
                        dump_data <= cksum ^ dump_data;
                        state     <= CKSUM;
`else
                        valid <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
`endif
                    end else begin
                        valid <= 1'b0;
                        cnt   <= cnt + 1'b1;
                        state <= READ;
                    end
                end
`ifdef DMEM_DUMP_CHECKSUM_EN
                CKSUM: if (hs) begin
                    valid <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
`endif
                DONE: begin
                    stall <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= FIRST_A;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Directed bench for dmem_dump_arbiter with a synchronous-read RAM model behind the port.
module tb_dmem_dump_arbiter;
`ifdef DMEM_DUMP_CHECKSUM_EN
    localparam int LAST = 3;
    localparam int NCK  = 1;
`else
    localparam int LAST = 255;
    localparam int NCK  = 0;
`endif
    localparam int FIRST    = 0;
    localparam int NWORDS   = LAST - FIRST + 1;
    localparam int RST_WORD = (LAST >= 40) ? 40 : 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        halted, stall, req, busy, done;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    dmem_dump_arbiter_if #(.NB_DATA(32)) dif ();

    dmem_dump_arbiter #(.NB_DATA(32), .NB_ADDR(8), .DUMP_FIRST(FIRST), .DUMP_LAST(LAST)) dut (
        .clk(clk), .i_reset(rst),
        .i_mem_we(mem_we), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata), .o_mem_rdata(mem_rdata),
        .i_pipe_halted(halted), .o_stall(stall),
        .i_dump_req(req), .o_dump_busy(busy), .dump(dif), .o_dump_done(done),
        .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] a, input logic [31:0] d);
        mem_we = 1'b1; mem_addr = a; mem_wdata = d;
        step();
        mem_we = 1'b0;
    endtask

    task automatic build_exp(input bit with5);
        logic [31:0] v, x;
        exp_q.delete();
        x = '0;
        for (int k = FIRST; k <= LAST; k++) begin
            v = (with5 && k == 5) ? 32'h0000_1234 : 32'(k * 3);
            exp_q.push_back(v);
            x ^= v;
        end
        if (NCK != 0) exp_q.push_back(x);
    endtask

    // One dump from request to return-to-IDLE; compares every beat with exp_q.
    task automatic do_dump(input bit rnd, input int halt_after, input bit store5, input bit poke, input string tag);
        int c, idx, last_t, ndone;
        bit pend, fin;
        logic [31:0] pdata;
        halted = 1'b0;
        req = 1'b1;
        if (store5) begin mem_we = 1'b1; mem_addr = 8'h05; mem_wdata = 32'h0000_1234; end
        step();
        req = 1'b0;
        c = 0; idx = 0; last_t = -1; ndone = 0; pend = 1'b0; fin = 1'b0; pdata = '0;
        while (!fin && c < 8000) begin
            halted = (c >= halt_after);
            dif.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (store5 && c == 0) begin
                mem_we = 1'b1; mem_addr = 8'h05; mem_wdata = 32'h0000_1234;
            end else if (poke && c == halt_after + 8) begin
                mem_we = 1'b1; mem_addr = 8'h07; mem_wdata = 32'hFFFF_FFFF;
            end else begin
                mem_we = 1'b0;
            end
            @(negedge clk);
            if (c == 0) begin
                chk({tag, "_stall_on"}, 32'(stall), 32'd1);
                chk({tag, "_busy_on"}, 32'(busy), 32'd1);
            end
            if (store5 && c == 0) begin
                chk({tag, "_halt_wait_we"}, 32'(ram_we), 32'd1);
                chk({tag, "_halt_wait_addr"}, 32'(ram_addr), 32'h05);
            end
            if (poke && c == halt_after + 8)
                chk({tag, "_we_dropped"}, 32'(ram_we), 32'd0);
            if (pend) begin
                chk({tag, "_valid_held"}, 32'(dif.valid), 32'd1);
                chk({tag, "_data_stable"}, dif.data, pdata);
            end
            if (dif.valid && dif.ready) begin
                if (idx < exp_q.size()) chk($sformatf("%s_beat%0d", tag, idx), dif.data, exp_q[idx]);
                else chk({tag, "_extra_beat"}, 32'(idx), 32'(exp_q.size()));
                if (!rnd && last_t >= 0 && idx < NWORDS) chk($sformatf("%s_gap%0d", tag, idx), 32'(c - last_t), 32'd3);
                last_t = c;
                idx++;
            end
            pend  = dif.valid && !dif.ready;
            pdata = dif.data;
            if (done) begin ndone++; fin = 1'b1; end
            step();
            c++;
        end
        mem_we = 1'b0;
        chk({tag, "_beats"}, 32'(idx), 32'(exp_q.size()));
        chk({tag, "_done_pulses"}, 32'(ndone), 32'd1);
        @(negedge clk);
        chk({tag, "_stall_off"}, 32'(stall), 32'd0);
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
        chk({tag, "_done_once"}, 32'(done), 32'd0);
        step();
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        exp_we;
        logic [7:0]  exp_addr;
        logic [31:0] exp_wdata;
        bit          chk_rd;
        logic [31:0] exp_rdata;
    } pt_vec_t;

    pt_vec_t pt [6];

    initial begin
        #2ms;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int hs, c;
        bit hit;
        pt[0] = '{1'b1, 8'h10, 32'hDEAD_BEEF, 1'b1, 8'h10, 32'hDEAD_BEEF, 1'b0, 32'h0};
        pt[1] = '{1'b1, 8'h20, 32'h0BAD_F00D, 1'b1, 8'h20, 32'h0BAD_F00D, 1'b0, 32'h0};
        pt[2] = '{1'b0, 8'h10, 32'h0000_0055, 1'b0, 8'h10, 32'h0000_0055, 1'b1, 32'hDEAD_BEEF};
        pt[3] = '{1'b0, 8'h20, 32'h0000_0000, 1'b0, 8'h20, 32'h0000_0000, 1'b1, 32'h0BAD_F00D};
        pt[4] = '{1'b1, 8'h10, 32'hCAFE_F00D, 1'b1, 8'h10, 32'hCAFE_F00D, 1'b0, 32'h0};
        pt[5] = '{1'b0, 8'h10, 32'h0000_0000, 1'b0, 8'h10, 32'h0000_0000, 1'b1, 32'hCAFE_F00D};

        rst = 1'b1; mem_we = 1'b0; mem_addr = 8'h33; mem_wdata = '0;
        halted = 1'b0; req = 1'b0; dif.ready = 1'b0;
        step(); step();
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(dif.valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", dif.data, 32'd0);
        chk("rst_mem_owns", 32'(ram_addr), 32'h33);
        step();
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            mem_we = pt[i].we; mem_addr = pt[i].addr; mem_wdata = pt[i].wdata;
            @(negedge clk);
            chk($sformatf("pt%0d_we", i), 32'(ram_we), 32'(pt[i].exp_we));
            chk($sformatf("pt%0d_addr", i), 32'(ram_addr), 32'(pt[i].exp_addr));
            chk($sformatf("pt%0d_wdata", i), ram_wdata, pt[i].exp_wdata);
            step();
            if (pt[i].chk_rd) chk($sformatf("pt%0d_rdata", i), mem_rdata, pt[i].exp_rdata);
        end
        mem_we = 1'b0;

        for (int k = 0; k < 256; k++) write_word(8'(k), 32'(k * 3));

        build_exp(1'b0);
        do_dump(1'b0, 2, 1'b0, 1'b0, "full");
        do_dump(1'b1, 0, 1'b0, 1'b0, "bp");

        build_exp(LAST >= 5);
        do_dump(1'b0, 3, 1'b1, 1'b1, "conflict");
        mem_addr = 8'h05; step();
        chk("store_landed", mem_rdata, 32'h0000_1234);
        mem_addr = 8'h07; step();
        chk("dropped_store", mem_rdata, 32'd21);

        // Reset while a beat is pending in SEND.
        halted = 1'b1; dif.ready = 1'b1;
        req = 1'b1; step(); req = 1'b0;
        hs = 0; c = 0; hit = 1'b0;
        while (!hit && c < 4000) begin
            if (dif.valid && hs == RST_WORD) hit = 1'b1;
            else begin
                @(negedge clk);
                if (dif.valid && dif.ready) hs++;
                step();
                c++;
            end
        end
        chk("rst_mid_reached", 32'(hit), 32'd1);
        dif.ready = 1'b0; rst = 1'b1;
        mem_we = 1'b1; mem_addr = 8'h77; mem_wdata = 32'(8'h77 * 3);
        @(negedge clk);
        chk("rst_mid_word", dif.data, exp_q[RST_WORD]);
        chk("rst_mid_mem_addr", 32'(ram_addr), 32'h77);
        chk("rst_mid_mem_we", 32'(ram_we), 32'd1);
        step();
        rst = 1'b0; mem_we = 1'b0; halted = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 32'(dif.valid), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        step();
        do_dump(1'b0, 1, 1'b0, 1'b0, "restart");

`ifdef DMEM_DUMP_CHECKSUM_EN
        write_word(8'h00, 32'h1);
        write_word(8'h01, 32'h2);
        write_word(8'h02, 32'h4);
        write_word(8'h03, 32'h8);
        exp_q.delete();
        exp_q.push_back(32'h1); exp_q.push_back(32'h2); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hF);
        do_dump(1'b0, 0, 1'b0, 1'b0, "cksum");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
